// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller for a 5-stage RISC-V pipeline:
// stall/flush enables, execute-stage forwarding selects, data-memory
// wait FSM with timeout, and saturating stall/flush counters.
module pipeline_hazard_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       Rs1E,
    input  logic [4:0]       Rs2E,
    input  logic [4:0]       RdE,
    input  logic [4:0]       RdM,
    input  logic [4:0]       RdW,
    input  logic [1:0]       ResultSrcE,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             PCSrcE,
    input  logic             MemReqM,
    input  logic             MemReadyM,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushW,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             MemErr,
    output logic [CNT_W-1:0] StallCnt,
    output logic [CNT_W-1:0] FlushCnt
);

    localparam int unsigned WCNT_W = $clog2(MEM_TIMEOUT);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR  = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [WCNT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]    flush_cnt_q, flush_cnt_d;
    logic                lw_hz;
    logic                mem_hz;
    logic                mem_stall;

    assign mem_stall = MemReqM && !MemReadyM;

    // FSM state and wait counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_RUN;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // FSM next-state: track consecutive not-ready cycles, ERR is sticky
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        unique case (state_q)
            ST_RUN: begin
                if (mem_stall) begin
                    state_d    = ST_WAIT;
                    wait_cnt_d = WCNT_W'(1);
                end
            end
            ST_WAIT: begin
                if (MemReadyM || !MemReqM) begin
                    state_d    = ST_RUN;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == WCNT_W'(MEM_TIMEOUT - 1)) begin
                    state_d = ST_ERR;
                end else begin
                    wait_cnt_d = wait_cnt_q + WCNT_W'(1);
                end
            end
            ST_ERR: begin
                state_d = ST_ERR;
            end
            default: begin
                state_d    = ST_RUN;
                wait_cnt_d = '0;
            end
        endcase
    end

    // Pipeline control outputs; a memory freeze overrides branch/load-use handling
    always_comb begin
        lw_hz  = (ResultSrcE == 2'b01) && (RdE != 5'd0) &&
                 ((RdE == Rs1D) || (RdE == Rs2D));
        mem_hz = mem_stall || (state_q == ST_ERR);
        StallF = 1'b0;
        StallD = 1'b0;
        StallE = 1'b0;
        StallM = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        FlushW = 1'b0;
        if (mem_hz) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            FlushW = 1'b1;
        end else begin
            StallF = lw_hz && !PCSrcE;
            StallD = lw_hz && !PCSrcE;
            FlushD = PCSrcE;
            FlushE = lw_hz || PCSrcE;
        end
    end

    // Forwarding selects: M beats W, x0 never forwards
    always_comb begin
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        if (RegWriteM && (RdM != 5'd0) && (RdM == Rs1E)) begin
            ForwardAE = 2'b10;
        end else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs1E)) begin
            ForwardAE = 2'b01;
        end
        if (RegWriteM && (RdM != 5'd0) && (RdM == Rs2E)) begin
            ForwardBE = 2'b10;
        end else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs2E)) begin
            ForwardBE = 2'b01;
        end
    end

    // Saturating counter next values
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (StallF && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (FlushD && (flush_cnt_q != {CNT_W{1'b1}})) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    // Performance counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign MemErr   = (state_q == ST_ERR);
    assign StallCnt = stall_cnt_q;
    assign FlushCnt = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl (MEM_TIMEOUT=4, CNT_W=4).
module tb_pipeline_hazard_ctrl;

    localparam int unsigned CNT_W = 4;
    localparam int unsigned NVEC  = 13;

    logic             clk;
    logic             rst;
    logic [4:0]       Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic [1:0]       ResultSrcE;
    logic             RegWriteM, RegWriteW, PCSrcE, MemReqM, MemReadyM;
    logic             StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
    logic [1:0]       ForwardAE, ForwardBE;
    logic             MemErr;
    logic [CNT_W-1:0] StallCnt, FlushCnt;

    int checks;
    int failures;

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RdM(RdM), .RdW(RdW), .ResultSrcE(ResultSrcE),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .PCSrcE(PCSrcE),
        .MemReqM(MemReqM), .MemReadyM(MemReadyM),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .MemErr(MemErr), .StallCnt(StallCnt), .FlushCnt(FlushCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
        logic [1:0]  rsrc;
        logic        rwm, rww, pcs, mreq, mrdy;
        logic [10:0] exp;   // {SF,SD,SE,SM, FD,FE,FW, FA[1:0], FB[1:0]}
    } vec_t;

    vec_t vecs [NVEC];

    function automatic logic [10:0] ctl_vec();
        return {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
                ForwardAE, ForwardBE};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_idle();
        Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
        ResultSrcE = 2'b00; RegWriteM = 0; RegWriteW = 0; PCSrcE = 0;
        MemReqM = 0; MemReadyM = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        set_idle();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic load_use(input logic pcs);
        ResultSrcE = 2'b01; RdE = 5'd5; Rs1D = 5'd5; PCSrcE = pcs;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1;
        set_idle();

        //                 rs1d rs2d rs1e rs2e rde rdm rdw rsrc  rwm rww pcs mreq mrdy exp
        vecs[0]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 2'b00, 0, 0, 0, 0, 0, 11'b0000_000_00_00};
        vecs[1]  = '{5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 5'd7, 5'd7, 2'b00, 1, 1, 0, 0, 0, 11'b0000_000_10_00};
        vecs[2]  = '{5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 5'd7, 5'd7, 2'b00, 0, 1, 0, 0, 0, 11'b0000_000_01_00};
        vecs[3]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 2'b00, 1, 1, 0, 0, 0, 11'b0000_000_00_00};
        vecs[4]  = '{5'd0, 5'd0, 5'd3, 5'd9, 5'd0, 5'd9, 5'd3, 2'b00, 1, 1, 0, 0, 0, 11'b0000_000_01_10};
        vecs[5]  = '{5'd0, 5'd0, 5'd4, 5'd5, 5'd0, 5'd4, 5'd5, 2'b00, 0, 1, 0, 0, 0, 11'b0000_000_00_01};
        vecs[6]  = '{5'd0, 5'd6, 5'd0, 5'd0, 5'd6, 5'd0, 5'd0, 2'b01, 0, 0, 0, 0, 0, 11'b1100_010_00_00};
        vecs[7]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 2'b01, 0, 0, 0, 0, 0, 11'b0000_000_00_00};
        vecs[8]  = '{5'd6, 5'd0, 5'd0, 5'd0, 5'd6, 5'd0, 5'd0, 2'b10, 0, 0, 0, 0, 0, 11'b0000_000_00_00};
        vecs[9]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 2'b00, 0, 0, 1, 0, 0, 11'b0000_110_00_00};
        vecs[10] = '{5'd6, 5'd0, 5'd0, 5'd0, 5'd6, 5'd0, 5'd0, 2'b01, 0, 0, 1, 1, 0, 11'b1111_001_00_00};
        vecs[11] = '{5'd6, 5'd0, 5'd0, 5'd0, 5'd6, 5'd0, 5'd0, 2'b01, 0, 0, 0, 1, 1, 11'b1100_010_00_00};
        vecs[12] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 2'b00, 0, 0, 0, 0, 0, 11'b0000_000_00_00};

        // Reset state
        do_reset();
        chk("reset_memerr", 32'(MemErr), 32'd0);
        chk("reset_stallcnt", 32'(StallCnt), 32'd0);
        chk("reset_flushcnt", 32'(FlushCnt), 32'd0);
        chk("reset_ctl", 32'(ctl_vec()), 32'd0);

        // Table-driven combinational vectors
        for (int i = 0; i < int'(NVEC); i++) begin
            @(negedge clk);
            Rs1D = vecs[i].rs1d; Rs2D = vecs[i].rs2d; Rs1E = vecs[i].rs1e;
            Rs2E = vecs[i].rs2e; RdE = vecs[i].rde; RdM = vecs[i].rdm;
            RdW = vecs[i].rdw; ResultSrcE = vecs[i].rsrc;
            RegWriteM = vecs[i].rwm; RegWriteW = vecs[i].rww;
            PCSrcE = vecs[i].pcs; MemReqM = vecs[i].mreq; MemReadyM = vecs[i].mrdy;
            #1;
            chk($sformatf("vec%0d_ctl", i), 32'(ctl_vec()), 32'(vecs[i].exp));
        end

        // Load-use: one stall cycle counted
        do_reset();
        @(negedge clk); load_use(1'b0); #1;
        chk("lu_ctl", 32'(ctl_vec()), 32'(11'b1100_010_00_00));
        @(posedge clk); #1;
        chk("lu_stallcnt", 32'(StallCnt), 32'd1);
        chk("lu_flushcnt", 32'(FlushCnt), 32'd0);

        // Load-use plus taken branch: branch wins
        do_reset();
        @(negedge clk); load_use(1'b1); #1;
        chk("lubr_ctl", 32'(ctl_vec()), 32'(11'b0000_110_00_00));
        @(posedge clk); #1;
        chk("lubr_flushcnt", 32'(FlushCnt), 32'd1);
        chk("lubr_stallcnt", 32'(StallCnt), 32'd0);

        // Memory wait of 3 cycles with pending branch, then ready
        do_reset();
        @(negedge clk); MemReqM = 1; MemReadyM = 0; PCSrcE = 1;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("wait%0d_ctl", c), 32'(ctl_vec()), 32'(11'b1111_001_00_00));
            @(negedge clk);
        end
        MemReadyM = 1; #1;
        chk("ready_ctl", 32'(ctl_vec()), 32'(11'b0000_110_00_00));
        @(posedge clk); #1;
        chk("wait_stallcnt", 32'(StallCnt), 32'd3);
        chk("wait_flushcnt", 32'(FlushCnt), 32'd1);
        chk("wait_memerr", 32'(MemErr), 32'd0);

        // MemReqM dropping in WAIT returns to RUN and restarts the timeout
        do_reset();
        @(negedge clk); MemReqM = 1; MemReadyM = 0;
        @(negedge clk);
        @(negedge clk); MemReqM = 0; #1;
        chk("drop_ctl", 32'(ctl_vec()), 32'd0);
        @(negedge clk); MemReqM = 1;
        repeat (3) @(negedge clk);
        chk("drop_no_err", 32'(MemErr), 32'd0);
        @(posedge clk); #1;
        chk("drop_err_late", 32'(MemErr), 32'd1);

        // Timeout into ERR at the 4th wait edge, sticky until reset
        do_reset();
        @(negedge clk); MemReqM = 1; MemReadyM = 0;
        for (int c = 1; c <= 4; c++) begin
            @(posedge clk); #1;
            chk($sformatf("to_edge%0d_memerr", c), 32'(MemErr), (c == 4) ? 32'd1 : 32'd0);
        end
        @(negedge clk); set_idle(); #1;
        chk("err_ctl", 32'(ctl_vec()), 32'(11'b1111_001_00_00));
        @(negedge clk); PCSrcE = 1; #1;
        chk("err_branch_ctl", 32'(ctl_vec()), 32'(11'b1111_001_00_00));
        chk("err_memerr", 32'(MemErr), 32'd1);
        @(negedge clk); PCSrcE = 0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_err_memerr", 32'(MemErr), 32'd0);
        chk("rst_err_stallcnt", 32'(StallCnt), 32'd0);
        chk("rst_err_flushcnt", 32'(FlushCnt), 32'd0);
        chk("rst_err_ctl", 32'(ctl_vec()), 32'd0);

        // Saturation of StallCnt at 2^CNT_W-1
        do_reset();
        @(negedge clk); load_use(1'b0);
        repeat (14) @(posedge clk);
        #1;
        chk("sat14_stallcnt", 32'(StallCnt), 32'd14);
        repeat (6) @(posedge clk);
        #1;
        chk("sat20_stallcnt", 32'(StallCnt), 32'd15);

        // Saturation of FlushCnt
        do_reset();
        @(negedge clk); PCSrcE = 1;
        repeat (20) @(posedge clk);
        #1;
        chk("sat20_flushcnt", 32'(FlushCnt), 32'd15);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
